float_mul_pipe: RTL and testbench

Three-stage pipelined multiplier for the 8-bit float format (sign[7], exp[6:4] with bias 3, mantissa[3:0]). It sits directly upstream of the float adder in each systolic processing element and forms the A×B product that the adder accumulates. A valid/ready handshake on both sides lets the array stall the PE without losing products.

---
 rtl/float_mul_pipe.sv | 161 ++++++++++++++++
 tb/tb_float_mul_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_mul_pipe.sv
// float_mul_pipe
// Three-stage pipelined multiplier for the 8-bit float format
// (sign[7], exp[6:4] bias 3, mantissa[3:0]; exp==0 means hidden bit 0).
// Feeds the float adder of a systolic PE. There is a valid/ready handshake
// on both sides, and the pipeline collapses bubbles.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand pair present
//   in_ready   pair is accepted this cycle (in_valid & in_ready)
//   a, b       multiplicand / multiplier
//   out_valid  product present
//   out_ready  consumer takes the product this cycle
//   out_data   product, held stable while stalled
//   out_ovf    product saturated to max magnitude
//   out_unf    nonzero product flushed to zero
module float_mul_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_ovf,
  output logic       out_unf
);

  // Pipeline control: a stage loads when it is empty or when its contents
  // move on this cycle. The chain is combinational from out_ready, so a
  // full pipe still accepts a new pair in the cycle a product leaves.
  logic ld1, ld2, ld3;
  logic v1_reg, v2_reg, v3_reg;

  assign ld3      = ~v3_reg | out_ready;
  assign ld2      = ~v2_reg | ld3;
  assign ld1      = ~v1_reg | ld2;
  assign in_ready = ld1;

  // ---------------- Stage 1: unpack and multiply ----------------
  logic [4:0] man_a, man_b;
  logic [9:0] prod_next;
  logic [3:0] esum_next;

  assign man_a     = {|a[6:4], a[3:0]};
  assign man_b     = {|b[6:4], b[3:0]};
  assign prod_next = {5'd0, man_a} * {5'd0, man_b};
  assign esum_next = {1'b0, a[6:4]} + {1'b0, b[6:4]};

  logic [9:0] prod1_reg;
  logic [3:0] esum1_reg;
  logic       s1_reg;

  // ---------------- Stage 2: normalise ----------------
  logic [3:0]        lead_idx;
  logic [3:0]        frac_next;
  logic signed [5:0] exp_next;

  // Leading-one index. The highest set bit wins because it is assigned last.
  always_comb begin
    lead_idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (prod1_reg[i]) lead_idx = 4'(i);
    end
  end

  // Shift the leading one up to bit 9. The four bits beneath it are the
  // fraction. Low bits are zero-filled when the product is small, and the
  // rest are truncated.
  always_comb begin
    frac_next = 4'((prod1_reg << (4'd9 - lead_idx)) >> 5);
  end

  // The product mantissa carries 8 fraction bits against a combined bias
  // of 6. The result exponent is esum + k - 11, which spans -11..12.
  assign exp_next = $signed({2'b00, esum1_reg}) + $signed({2'b00, lead_idx}) - 6'sd11;

  logic              s2_reg;
  logic              zero2_reg;
  logic signed [5:0] exp2_reg;
  logic [3:0]        frac2_reg;

  // ---------------- Stage 3: pack ----------------
  logic [7:0] pack_data;
  logic       pack_ovf, pack_unf;

  // Zero and underflow results are emitted as +0.
  always_comb begin
    pack_data = {s2_reg, exp2_reg[2:0], frac2_reg};
    pack_ovf  = 1'b0;
    pack_unf  = 1'b0;
    if (zero2_reg) begin
      pack_data = 8'h00;
    end else if (exp2_reg > 6'sd7) begin
      pack_data = {s2_reg, 7'h7F};
      pack_ovf  = 1'b1;
    end else if (exp2_reg < 6'sd1) begin
      pack_data = 8'h00;
      pack_unf  = 1'b1;
    end
  end

  logic [7:0] data3_reg;
  logic       ovf3_reg, unf3_reg;

  // ---------------- Registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      v3_reg    <= 1'b0;
      prod1_reg <= 10'd0;
      esum1_reg <= 4'd0;
      s1_reg    <= 1'b0;
      s2_reg    <= 1'b0;
      zero2_reg <= 1'b0;
      exp2_reg  <= 6'sd0;
      frac2_reg <= 4'd0;
      data3_reg <= 8'h00;
      ovf3_reg  <= 1'b0;
      unf3_reg  <= 1'b0;
    end else begin
      if (ld1) begin
        v1_reg <= in_valid;
        if (in_valid) begin
          prod1_reg <= prod_next;
          esum1_reg <= esum_next;
          s1_reg    <= a[7] ^ b[7];
        end
      end
      if (ld2) begin
        v2_reg <= v1_reg;
        if (v1_reg) begin
          s2_reg    <= s1_reg;
          zero2_reg <= (prod1_reg == 10'd0);
          exp2_reg  <= exp_next;
          frac2_reg <= frac_next;
        end
      end
      // Output registers change only when a new product enters stage 3.
      // This keeps them stable while the consumer stalls.
      if (ld3) begin
        v3_reg <= v2_reg;
        if (v2_reg) begin
          data3_reg <= pack_data;
          ovf3_reg  <= pack_ovf;
          unf3_reg  <= pack_unf;
        end
      end
    end
  end

  assign out_valid = v3_reg;
  assign out_data  = data3_reg;
  assign out_ovf   = ovf3_reg;
  assign out_unf   = unf3_reg;

endmodule

// File: tb/tb_float_mul_pipe.sv
// tb_float_mul_pipe
// Self-checking bench for float_mul_pipe.
// A value-level reference model runs alongside the DUT. It scales every
// value by 2^14 so all arithmetic stays in integers. A monitor checks each
// cycle that out_valid is high against a FIFO of expected products.
// Directed vectors also pin literal expectations.
module tb_float_mul_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_ovf;
  logic       out_unf;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] data;
    logic       ovf;
    logic       unf;
  } item_t;

  item_t exp_q[$];

  always #5 clk = ~clk;

  float_mul_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Reference model. Each operand is M * 2^(e-7), where M includes the
  // hidden bit. v is the exact product scaled by 2^14. A normal result
  // with exponent E covers [16, 32) * 2^(E-7).
  function automatic item_t model(input logic [7:0] x, input logic [7:0] y);
    item_t  r;
    int     mx, my, ex, ey;
    longint v;
    logic   s;
    r.a    = x;
    r.b    = y;
    r.data = 8'h00;
    r.ovf  = 1'b0;
    r.unf  = 1'b0;
    s  = x[7] ^ y[7];
    mx = (x[6:4] != 3'd0 ? 16 : 0) + int'(x[3:0]);
    my = (y[6:4] != 3'd0 ? 16 : 0) + int'(y[3:0]);
    ex = int'(x[6:4]);
    ey = int'(y[6:4]);
    v  = longint'(mx * my) << (ex + ey);
    if (v == 0) begin
      r.data = 8'h00;
    end else if (v >= (longint'(32) << 14)) begin
      r.data = {s, 7'h7F};
      r.ovf  = 1'b1;
    end else if (v < (longint'(16) << 8)) begin
      r.unf = 1'b1;
    end else begin
      for (int e = 1; e <= 7; e++) begin
        if (v >= (longint'(16) << (e + 7)) && v < (longint'(32) << (e + 7)))
          r.data = {s, 3'(e), 4'((v >> (e + 7)) - 16)};
      end
    end
    return r;
  endfunction

  // Monitor: sample at the falling edge, away from the active edge.
  logic [7:0] held_data;
  logic       held = 1'b0;
  item_t      mon_it;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (out_valid) begin
        check("queue_nonempty_on_out_valid", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          check("out_data", out_data, exp_q[0].data);
          check("out_ovf", out_ovf, exp_q[0].ovf);
          check("out_unf", out_unf, exp_q[0].unf);
          if (out_ready) begin
            mon_it = exp_q.pop_front();
            pops++;
            $display("out: 0x%02h x 0x%02h -> 0x%02h ovf=%0b unf=%0b",
                     mon_it.a, mon_it.b, out_data, out_ovf, out_unf);
          end
        end
        if (held) check("stall_stable", out_data, held_data);
      end
      held      = out_valid & ~out_ready;
      held_data = out_data;
      if (in_valid && in_ready) exp_q.push_back(model(a, b));
    end
  end

  // Present one pair to an empty pipe and check the product. Latency is
  // counted in clock edges, including the accepting edge.
  task automatic run_pair(input logic [7:0] xa, input logic [7:0] xb,
                          input logic [7:0] wd, input logic wo, input logic wu);
    item_t m;
    int    lat;
    m = model(xa, xb);
    check("model_pin_data", m.data, wd);
    check("model_pin_flags", {m.ovf, m.unf}, {wo, wu});
    a = xa;
    b = xb;
    in_valid = 1'b1;
    check("pair_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 3);
    check("pair_data", out_data, wd);
    check("pair_ovf", out_ovf, wo);
    check("pair_unf", out_unf, wu);
    @(posedge clk); #1;
  endtask

  logic [7:0] st_a [8] = '{8'h30, 8'h38, 8'hB0, 8'h00, 8'h08, 8'h7F, 8'h10, 8'hC5};
  logic [7:0] st_b [8] = '{8'h30, 8'h40, 8'h30, 8'h5A, 8'h50, 8'h7F, 8'h10, 8'h4B};
  logic [7:0] bp_a [4] = '{8'h30, 8'h38, 8'hB0, 8'h08};
  logic [7:0] bp_b [4] = '{8'h30, 8'h40, 8'h30, 8'h50};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         first, last, nv, nrdy_low, pops0, wait_cyc;
    logic [7:0] hold_val;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 8'h00;
    b         = 8'h00;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_flags", {out_ovf, out_unf}, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors
    run_pair(8'h30, 8'h30, 8'h30, 1'b0, 1'b0);
    run_pair(8'h38, 8'h40, 8'h48, 1'b0, 1'b0);
    run_pair(8'hB0, 8'h30, 8'hB0, 1'b0, 1'b0);
    run_pair(8'h00, 8'h5A, 8'h00, 1'b0, 1'b0);
    run_pair(8'h08, 8'h50, 8'h10, 1'b0, 1'b0);
    run_pair(8'h7F, 8'h7F, 8'h7F, 1'b1, 1'b0);
    run_pair(8'hFF, 8'h7F, 8'hFF, 1'b1, 1'b0);
    run_pair(8'h10, 8'h10, 8'h00, 1'b0, 1'b1);

    // Streaming: 8 back-to-back pairs with out_ready high
    first = -1; last = -1; nv = 0; nrdy_low = 0;
    for (int t = 0; t < 13; t++) begin
      if (t < 8) begin
        a = st_a[t];
        b = st_b[t];
        in_valid = 1'b1;
        if (!in_ready) nrdy_low++;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        nv++;
        if (first < 0) first = t;
        last = t;
      end
      @(posedge clk); #1;
    end
    check("stream_in_ready_low_cycles", nrdy_low, 0);
    check("stream_products", nv, 8);
    check("stream_first_cycle", first, 3);
    check("stream_last_cycle", last, 10);
    check("stream_queue_drained", exp_q.size(), 0);

    // Backpressure: offer 4 pairs while out_ready is low
    out_ready = 1'b0;
    pops0 = pops;
    for (int j = 0; j < 4; j++) begin
      a = bp_a[j];
      b = bp_b[j];
      in_valid = 1'b1;
      check("bp_in_ready", in_ready, (j < 3) ? 1 : 0);
      if (j < 3) begin
        @(posedge clk); #1;
      end
    end
    check("bp_out_valid", out_valid, 1);
    check("bp_first_data", out_data, 8'h30);
    hold_val = out_data;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      check("bp_stall_in_ready", in_ready, 0);
      check("bp_stall_data", out_data, hold_val);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 12) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    check("bp_queue_drained", exp_q.size(), 0);
    check("bp_products", pops - pops0, 4);

    // Reset with 2 products in flight
    out_ready = 1'b0;
    a = 8'h7F; b = 8'h7F; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h30; b = 8'h30;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_out_valid", out_valid, 1);
    check("pre_reset_out_data", out_data, 8'h7F);
    check("pre_reset_out_ovf", out_ovf, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_out_valid", out_valid, 0);
    check("async_reset_out_data", out_data, 0);
    check("async_reset_flags", {out_ovf, out_unf}, 0);
    check("async_reset_in_ready", in_ready, 1);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_reset_out_valid", out_valid, 0);
    check("post_reset_queue", exp_q.size(), 0);
    run_pair(8'h30, 8'h30, 8'h30, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
